// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide HCI-style TCDM stream into MP independent 32-bit narrow ports.
// Optional macro REDMULE_SPLIT_BE_SKIP_EN: ports with all-zero byte enables are skipped.
module redmule_tcdm_splitter #(
    parameter int unsigned MP      = 8,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned AW      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wide_req_i,
    output logic             wide_gnt_o,
    input  logic [AW-1:0]    wide_add_i,
    input  logic             wide_wen_i,
    input  logic [MP*4-1:0]  wide_be_i,
    input  logic [MP*32-1:0] wide_data_i,
    output logic [MP*32-1:0] wide_r_data_o,
    output logic             wide_r_valid_o,
    output logic [MP-1:0]    tcdm_req_o,
    input  logic [MP-1:0]    tcdm_gnt_i,
    output logic [MP*AW-1:0] tcdm_add_o,
    output logic [MP-1:0]    tcdm_wen_o,
    output logic [MP*4-1:0]  tcdm_be_o,
    output logic [MP*32-1:0] tcdm_data_o,
    input  logic [MP*32-1:0] tcdm_r_data_i,
    input  logic [MP-1:0]    tcdm_r_valid_i,
    output logic             err_o
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 2);
    localparam logic [CW-1:0] CntMax  = CW'(MAX_OUT);
    localparam logic [PW-1:0] PtrLast = PW'(MAX_OUT - 1);
    localparam logic [OW-1:0] OwedMax = '1;

    typedef enum logic {StIdle, StPartial} state_e;

    state_e        state_q, state_d;
    logic [MP-1:0] granted_q, granted_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [MP-1:0]    active, skip_head, nar_gnt, fifo_ne, push_err;
    logic [MP*32-1:0] heads;
    logic             has_room, done, abort;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PtrLast) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        tcdm_add_o = '0;
        for (int k = 0; k < MP; k++) begin
            tcdm_add_o[k*AW +: AW] = wide_add_i + AW'(4 * k);
        end
    end

    assign tcdm_be_o   = wide_be_i;
    assign tcdm_data_o = wide_data_i;
    assign tcdm_wen_o  = {MP{wide_wen_i}};

`ifdef REDMULE_SPLIT_BE_SKIP_EN
    logic [MP-1:0] skip_mem_q [MAX_OUT];
    logic [PW-1:0] skip_wptr_q, skip_rptr_q;

    always_comb begin
        active = '0;
        for (int k = 0; k < MP; k++) begin
            active[k] = |wide_be_i[4*k +: 4];
        end
    end

    // Occupancy of the skip FIFO always equals cnt_q, so no separate counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                skip_mem_q[i] <= '0;
            end
            skip_wptr_q <= '0;
            skip_rptr_q <= '0;
        end else begin
            if (wide_gnt_o) begin
                skip_mem_q[skip_wptr_q] <= ~active;
                skip_wptr_q             <= ptr_inc(skip_wptr_q);
            end
            if (wide_r_valid_o) begin
                skip_rptr_q <= ptr_inc(skip_rptr_q);
            end
        end
    end

    assign skip_head = (cnt_q != '0) ? skip_mem_q[skip_rptr_q] : '0;
`else
    assign active    = '1;
    assign skip_head = '0;
`endif

    // Handshake outputs are forced low while reset is asserted.
    assign has_room       = cnt_q < CntMax;
    assign tcdm_req_o     = {MP{wide_req_i & has_room & ~rst_i}} & ~granted_q & active;
    assign nar_gnt        = tcdm_gnt_i & tcdm_req_o;
    assign done           = &(granted_q | nar_gnt | ~active);
    assign wide_gnt_o     = wide_req_i & has_room & done & ~rst_i;
    assign wide_r_valid_o = (cnt_q != '0) & (&(fifo_ne | skip_head));
    assign wide_r_data_o  = wide_r_valid_o ? heads : '0;
    assign abort          = (state_q == StPartial) & ~wide_req_i;
    assign err_o          = err_q;

    for (genvar k = 0; k < MP; k++) begin : g_port
        logic [31:0]   mem_q [MAX_OUT];
        logic [PW-1:0] wptr_q, rptr_q;
        logic [CW-1:0] fcnt_q;
        logic [OW-1:0] owed_q;
        logic          owed, full, push, pop, inc, dec;

        assign owed        = owed_q != '0;
        assign full        = fcnt_q == CntMax;
        assign push        = tcdm_r_valid_i[k] & owed & ~full;
        assign pop         = wide_r_valid_o & ~skip_head[k];
        assign dec         = tcdm_r_valid_i[k] & owed;
        assign inc         = nar_gnt[k] & ((owed_q != OwedMax) | dec);
        assign push_err[k] = tcdm_r_valid_i[k] & ~push;
        assign fifo_ne[k]  = fcnt_q != '0;
        assign heads[32*k +: 32] = skip_head[k] ? 32'h0 : mem_q[rptr_q];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < MAX_OUT; i++) begin
                    mem_q[i] <= '0;
                end
                wptr_q <= '0;
                rptr_q <= '0;
                fcnt_q <= '0;
                owed_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= tcdm_r_data_i[32*k +: 32];
                    wptr_q        <= ptr_inc(wptr_q);
                end
                if (pop) begin
                    rptr_q <= ptr_inc(rptr_q);
                end
                case ({push, pop})
                    2'b10:   fcnt_q <= fcnt_q + CW'(1);
                    2'b01:   fcnt_q <= fcnt_q - CW'(1);
                    default: fcnt_q <= fcnt_q;
                endcase
                // An overflowing response still settles the beat it was owed for.
                case ({inc, dec})
                    2'b10:   owed_q <= owed_q + OW'(1);
                    2'b01:   owed_q <= owed_q - OW'(1);
                    default: owed_q <= owed_q;
                endcase
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        granted_d = granted_q;
        err_d     = err_q | (|push_err);
        unique case (state_q)
            StIdle: begin
                if (!wide_gnt_o) begin
                    granted_d = granted_q | nar_gnt;
                    if (|nar_gnt) state_d = StPartial;
                end else begin
                    granted_d = '0;
                end
            end
            StPartial: begin
                if (wide_gnt_o) begin
                    granted_d = '0;
                    state_d   = StIdle;
                end else if (abort) begin
                    granted_d = '0;
                    err_d     = 1'b1;
                    state_d   = StIdle;
                end else begin
                    granted_d = granted_q | nar_gnt;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({wide_gnt_o, wide_r_valid_o})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            granted_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            granted_q <= granted_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Directed self-checking bench for redmule_tcdm_splitter (MP=4, MAX_OUT=2, AW=32).
module tb_redmule_tcdm_splitter;

    logic         clk = 1'b0;
    logic         rst;
    logic         wide_req, wide_gnt, wide_wen, wide_r_valid, err;
    logic [31:0]  wide_add;
    logic [15:0]  wide_be, tcdm_be;
    logic [127:0] wide_data, wide_r_data, tcdm_add, tcdm_data, tcdm_r_data;
    logic [3:0]   tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;

    int errors = 0;
    int checks = 0;

    redmule_tcdm_splitter #(.MP(4), .MAX_OUT(2), .AW(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wide_req_i     (wide_req),
        .wide_gnt_o     (wide_gnt),
        .wide_add_i     (wide_add),
        .wide_wen_i     (wide_wen),
        .wide_be_i      (wide_be),
        .wide_data_i    (wide_data),
        .wide_r_data_o  (wide_r_data),
        .wide_r_valid_o (wide_r_valid),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wide_req = 1'b0; wide_add = '0; wide_wen = 1'b0; wide_be = '0;
        wide_data = '0; tcdm_gnt = '0; tcdm_r_data = '0; tcdm_r_valid = '0;
        #2;
        chk("rst_req", 128'(tcdm_req), 128'(4'h0));
        chk("rst_gnt", 128'(wide_gnt), 128'(1'b0));
        chk("rst_rvalid", 128'(wide_r_valid), 128'(1'b0));
        chk("rst_rdata", wide_r_data, 128'h0);
        chk("rst_err", 128'(err), 128'(1'b0));
        tick();
        rst = 1'b0;

        // Address wrap at the top of the address space.
        wide_add = 32'hFFFF_FFF8;
        #1;
        chk("addr_wrap", tcdm_add, 128'h00000004_00000000_FFFFFFFC_FFFFFFF8);

        // All four ports grant in the same cycle.
        wide_req = 1'b1; wide_add = 32'h100; wide_wen = 1'b1; wide_be = 16'h1234;
        wide_data = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000; tcdm_gnt = 4'hF;
        #1;
        chk("t1_addr", tcdm_add, 128'h0000010C_00000108_00000104_00000100);
        chk("t1_req", 128'(tcdm_req), 128'(4'hF));
        chk("t1_gnt", 128'(wide_gnt), 128'(1'b1));
        chk("t1_wen", 128'(tcdm_wen), 128'(4'hF));
        chk("t1_be", 128'(tcdm_be), 128'(16'h1234));
        chk("t1_data", tcdm_data, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000);
        tick();
        wide_req = 1'b0; tcdm_gnt = 4'h0; wide_be = 16'hFFFF;
        tcdm_r_valid = 4'hF; tcdm_r_data = 128'h44444444_33333333_22222222_11111111;
        #1;
        chk("t1_rv_early", 128'(wide_r_valid), 128'(1'b0));
        tick();
        tcdm_r_valid = 4'h0; tcdm_r_data = '0;
        #1;
        chk("t1_rvalid", 128'(wide_r_valid), 128'(1'b1));
        chk("t1_rdata", wide_r_data, 128'h44444444_33333333_22222222_11111111);
        tick();
        chk("t1_rv_done", 128'(wide_r_valid), 128'(1'b0));

        // Port 2 grants three cycles after the others.
        wide_req = 1'b1; wide_add = 32'h200; wide_wen = 1'b0; tcdm_gnt = 4'b1011;
        #1;
        chk("t2_req0", 128'(tcdm_req), 128'(4'hF));
        chk("t2_gnt0", 128'(wide_gnt), 128'(1'b0));
        chk("t2_wen", 128'(tcdm_wen), 128'(4'h0));
        chk("t2_addr", tcdm_add, 128'h0000020C_00000208_00000204_00000200);
        tick();
        tcdm_gnt = 4'h0;
        #1;
        chk("t2_req1", 128'(tcdm_req), 128'(4'b0100));
        chk("t2_gnt1", 128'(wide_gnt), 128'(1'b0));
        tick();
        chk("t2_req2", 128'(tcdm_req), 128'(4'b0100));
        tick();
        tcdm_gnt = 4'b0100;
        #1;
        chk("t2_req3", 128'(tcdm_req), 128'(4'b0100));
        chk("t2_gnt3", 128'(wide_gnt), 128'(1'b1));
        tick();
        wide_req = 1'b0; tcdm_gnt = 4'h0;

        // Staggered responses: ports 0-2 at t, port 3 at t+4.
        tcdm_r_valid = 4'b0111; tcdm_r_data = 128'h00000000_000000A2_000000A1_000000A0;
        #1;
        chk("t3_rv_t0", 128'(wide_r_valid), 128'(1'b0));
        tick();
        tcdm_r_valid = 4'h0; tcdm_r_data = '0;
        for (int i = 1; i < 4; i++) begin
            chk("t3_rv_wait", 128'(wide_r_valid), 128'(1'b0));
            tick();
        end
        tcdm_r_valid = 4'b1000; tcdm_r_data = 128'h000000A3_00000000_00000000_00000000;
        #1;
        chk("t3_rv_t4", 128'(wide_r_valid), 128'(1'b0));
        tick();
        tcdm_r_valid = 4'h0; tcdm_r_data = '0;
        #1;
        chk("t3_rvalid", 128'(wide_r_valid), 128'(1'b1));
        chk("t3_rdata", wide_r_data, 128'h000000A3_000000A2_000000A1_000000A0);
        tick();
        chk("t3_rv_done", 128'(wide_r_valid), 128'(1'b0));

        // Outstanding limit, no bypass on pop, accept and pop together.
        wide_req = 1'b1; wide_add = 32'h300; tcdm_gnt = 4'hF;
        #1;
        chk("t4_acc1", 128'(wide_gnt), 128'(1'b1));
        tick();
        wide_add = 32'h310;
        #1;
        chk("t4_acc2", 128'(wide_gnt), 128'(1'b1));
        tick();
        wide_add = 32'h320;
        #1;
        chk("t4_stall_req", 128'(tcdm_req), 128'(4'h0));
        chk("t4_stall_gnt", 128'(wide_gnt), 128'(1'b0));
        tick();
        tcdm_r_valid = 4'hF; tcdm_r_data = 128'h00003003_00003002_00003001_00003000;
        #1;
        chk("t4_stall_req2", 128'(tcdm_req), 128'(4'h0));
        tick();
        tcdm_r_valid = 4'h0;
        #1;
        chk("t4_pop1_rv", 128'(wide_r_valid), 128'(1'b1));
        chk("t4_pop1_data", wide_r_data, 128'h00003003_00003002_00003001_00003000);
        chk("t4_nobypass_req", 128'(tcdm_req), 128'(4'h0));
        chk("t4_nobypass_gnt", 128'(wide_gnt), 128'(1'b0));
        tick();
        chk("t4_acc3_req", 128'(tcdm_req), 128'(4'hF));
        chk("t4_acc3_gnt", 128'(wide_gnt), 128'(1'b1));
        tick();
        wide_req = 1'b0; tcdm_gnt = 4'h0;
        tcdm_r_valid = 4'hF; tcdm_r_data = 128'h00003103_00003102_00003101_00003100;
        tick();
        tcdm_r_valid = 4'h0;
        #1;
        chk("t4_pop2_data", wide_r_data, 128'h00003103_00003102_00003101_00003100);
        tick();
        tcdm_r_valid = 4'hF; tcdm_r_data = 128'h00003203_00003202_00003201_00003200;
        tick();
        tcdm_r_valid = 4'h0; wide_req = 1'b1; wide_add = 32'h330; tcdm_gnt = 4'hF;
        #1;
        chk("t4_pop3_data", wide_r_data, 128'h00003203_00003202_00003201_00003200);
        chk("t4_acc4_gnt", 128'(wide_gnt), 128'(1'b1));
        tick();
        wide_req = 1'b0; tcdm_gnt = 4'h0;
        tcdm_r_valid = 4'hF; tcdm_r_data = 128'h00003303_00003302_00003301_00003300;
        tick();
        tcdm_r_valid = 4'h0;
        #1;
        chk("t4_pop4_rv", 128'(wide_r_valid), 128'(1'b1));
        chk("t4_pop4_data", wide_r_data, 128'h00003303_00003302_00003301_00003300);
        tick();
        chk("t4_drained", 128'(wide_r_valid), 128'(1'b0));
        chk("t4_err", 128'(err), 128'(1'b0));

`ifdef REDMULE_SPLIT_BE_SKIP_EN
        wide_req = 1'b1; wide_add = 32'h500; wide_be = 16'h0F0F; tcdm_gnt = 4'b0101;
        #1;
        chk("be_req", 128'(tcdm_req), 128'(4'b0101));
        chk("be_gnt", 128'(wide_gnt), 128'(1'b1));
        tick();
        wide_req = 1'b0; wide_be = 16'hFFFF; tcdm_gnt = 4'h0;
        tcdm_r_valid = 4'b0101; tcdm_r_data = 128'h0000DEAD_00000052_0000DEAD_00000050;
        tick();
        tcdm_r_valid = 4'h0;
        #1;
        chk("be_rvalid", 128'(wide_r_valid), 128'(1'b1));
        chk("be_rdata", wide_r_data, 128'h00000000_00000052_00000000_00000050);
        tick();
        wide_req = 1'b1; wide_be = 16'h0000;
        #1;
        chk("be0_req", 128'(tcdm_req), 128'(4'h0));
        chk("be0_gnt", 128'(wide_gnt), 128'(1'b1));
        tick();
        wide_req = 1'b0; wide_be = 16'hFFFF;
        #1;
        chk("be0_rvalid", 128'(wide_r_valid), 128'(1'b1));
        chk("be0_rdata", wide_r_data, 128'h0);
        tick();
`endif

        // Request dropped while partially granted.
        wide_req = 1'b1; wide_add = 32'h400; tcdm_gnt = 4'b0001;
        #1;
        chk("t5_gnt", 128'(wide_gnt), 128'(1'b0));
        tick();
        wide_req = 1'b0; tcdm_gnt = 4'h0;
        #1;
        chk("t5_err_pre", 128'(err), 128'(1'b0));
        tick();
        chk("t5_err", 128'(err), 128'(1'b1));
        tick();
        wide_req = 1'b1; tcdm_gnt = 4'b1110;
        #1;
        chk("t5_err_sticky", 128'(err), 128'(1'b1));
        chk("t5_cleared_req", 128'(tcdm_req), 128'(4'hF));
        chk("t5_cleared_gnt", 128'(wide_gnt), 128'(1'b0));
        tick();

        // Reset in the middle of a partially granted transfer.
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 128'(tcdm_req), 128'(4'h0));
        chk("t6_rst_gnt", 128'(wide_gnt), 128'(1'b0));
        chk("t6_rst_rv", 128'(wide_r_valid), 128'(1'b0));
        chk("t6_rst_rdata", wide_r_data, 128'h0);
        chk("t6_rst_err", 128'(err), 128'(1'b0));
        tick();
        rst = 1'b0;
        #1;
        chk("t6_post_gnt", 128'(wide_gnt), 128'(1'b0));
        tick();
        tcdm_gnt = 4'b0001;
        #1;
        chk("t6_late_gnt", 128'(wide_gnt), 128'(1'b1));
        tick();
        wide_req = 1'b0; tcdm_gnt = 4'h0;
        tcdm_r_valid = 4'hF; tcdm_r_data = 128'h00006003_00006002_00006001_00006000;
        tick();
        tcdm_r_valid = 4'b0001; tcdm_r_data = 128'h0000BEEF;
        #1;
        chk("t7_rdata", wide_r_data, 128'h00006003_00006002_00006001_00006000);
        tick();
        tcdm_r_valid = 4'h0;
        #1;
        chk("t7_stray_err", 128'(err), 128'(1'b1));
        chk("t7_stray_rv", 128'(wide_r_valid), 128'(1'b0));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
